// File: rtl/uart_tx_ctrl_if.sv
// Host-side byte interface and serial line outputs of the UART transmit sequencer.
// The master drives the byte request; the slave (uart_tx_ctrl) returns line and status.
interface uart_tx_ctrl_if #(
   parameter int DATA_WIDTH = 8
) ();

   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_en;
   logic                  par_typ;
   logic                  tx_out;
   logic                  busy;
   logic                  frame_done;

   modport master (
      output p_data,
      output data_valid,
      output par_en,
      output par_typ,
      input  tx_out,
      input  busy,
      input  frame_done
   );

   modport slave (
      input  p_data,
      input  data_valid,
      input  par_en,
      input  par_typ,
      output tx_out,
      output busy,
      output frame_done
   );

endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, LSB-first data, optional parity, stop bit.
// One clk period is one bit time; every output is registered alongside the state.
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_ctrl_if.slave bus
);

   localparam int              CW       = $clog2(DATA_WIDTH) + 1;
   localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [CW-1:0]         bit_cnt;
   logic                  par_en_q;
   logic                  par_bit;
   logic                  accept;

   // A request is only taken while idle or on the stop bit; anything else is dropped.
   assign accept = bus.data_valid && ((state == IDLE) || (state == STOP));

   // tx_out is loaded with the value belonging to the state being entered, so the
   // line changes on the same edge as the state and never glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         shift_reg      <= '0;
         bit_cnt        <= '0;
         par_en_q       <= 1'b0;
         par_bit        <= 1'b0;
         bus.tx_out     <= 1'b1;
         bus.busy       <= 1'b0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.frame_done <= 1'b0;
         case (state)
            IDLE, STOP: begin
               if (state == STOP) begin
                  bus.frame_done <= 1'b1;
               end
               if (accept) begin
                  shift_reg  <= bus.p_data;
                  par_en_q   <= bus.par_en;
                  par_bit    <= (^bus.p_data) ^ bus.par_typ;
                  bit_cnt    <= '0;
                  state      <= START;
                  bus.tx_out <= 1'b0;
                  bus.busy   <= 1'b1;
               end else begin
                  state      <= IDLE;
                  bus.tx_out <= 1'b1;
                  bus.busy   <= 1'b0;
               end
            end

            START: begin
               state      <= DATA;
               bit_cnt    <= '0;
               bus.tx_out <= shift_reg[0];
               shift_reg  <= shift_reg >> 1;
            end

            DATA: begin
               if (bit_cnt == LAST_BIT) begin
                  if (par_en_q) begin
                     state      <= PARITY;
                     bus.tx_out <= par_bit;
                  end else begin
                     state      <= STOP;
                     bus.tx_out <= 1'b1;
                  end
               end else begin
                  bit_cnt    <= bit_cnt + CW'(1);
                  bus.tx_out <= shift_reg[0];
                  shift_reg  <= shift_reg >> 1;
               end
            end

            PARITY: begin
               state      <= STOP;
               bus.tx_out <= 1'b1;
            end

            default: begin
               state      <= IDLE;
               bus.tx_out <= 1'b1;
               bus.busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: per-cycle line expectations queued at each
// accepted request and popped/compared on every falling edge.
module tb_uart_tx_ctrl;

   typedef struct packed {
      logic tx;
      logic busy;
      logic done;
   } line_t;

   typedef struct {
      logic [7:0] data;
      logic       pe;
      logic       pt;
      logic       exp_par;
   } vec_t;

   logic  clk;
   logic  rst;
   int    n_compared;
   int    n_mismatched;
   int    cycle;
   line_t exp_q[$];
   vec_t  vecs[7];

   uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

   uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input line_t act, input line_t exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got tx/busy/done=%b expected %b", name, act, exp);
      end
   endtask

   // An empty queue means the line must be idle.
   always @(negedge clk) begin
      line_t e;
      cycle++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
      checkOutput($sformatf("line@%0d", cycle), {bus.tx_out, bus.busy, bus.frame_done}, e);
   end

   function automatic void push_frame(input logic [7:0] d, input logic pe, input logic par,
                                      input logic first_done, input logic tail);
      exp_q.push_back('{tx: 1'b0, busy: 1'b1, done: first_done});
      for (int i = 0; i < 8; i++) exp_q.push_back('{tx: d[i], busy: 1'b1, done: 1'b0});
      if (pe) exp_q.push_back('{tx: par, busy: 1'b1, done: 1'b0});
      exp_q.push_back('{tx: 1'b1, busy: 1'b1, done: 1'b0});
      if (tail) exp_q.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b1});
   endfunction

   // One-cycle request; returns #1 after the accepting edge.
   task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt);
      @(posedge clk);
      #1;
      bus.p_data     = d;
      bus.par_en     = pe;
      bus.par_typ    = pt;
      bus.data_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.data_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL %s: %0d expected cycles never observed, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, required finish before 100000");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      n_compared     = 0;
      n_mismatched   = 0;
      cycle          = 0;
      bus.p_data     = '0;
      bus.data_valid = 1'b0;
      bus.par_en     = 1'b0;
      bus.par_typ    = 1'b0;

      vecs[0] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, exp_par: 1'b0};
      vecs[1] = '{data: 8'h01, pe: 1'b1, pt: 1'b1, exp_par: 1'b0};
      vecs[2] = '{data: 8'h01, pe: 1'b1, pt: 1'b0, exp_par: 1'b1};
      vecs[3] = '{data: 8'hFF, pe: 1'b0, pt: 1'b0, exp_par: 1'b0};
      vecs[4] = '{data: 8'h3C, pe: 1'b1, pt: 1'b1, exp_par: 1'b1};
      vecs[5] = '{data: 8'h80, pe: 1'b1, pt: 1'b0, exp_par: 1'b1};
      vecs[6] = '{data: 8'h00, pe: 1'b0, pt: 1'b1, exp_par: 1'b0};

      rst = 1'b1;
      #2;
      checkOutput("reset_state", {bus.tx_out, bus.busy, bus.frame_done}, '{1'b1, 1'b0, 1'b0});
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);

      $display("[TB] table-driven frames");
      foreach (vecs[k]) begin
         applyStimulus(vecs[k].data, vecs[k].pe, vecs[k].pt);
         push_frame(vecs[k].data, vecs[k].pe, vecs[k].exp_par, 1'b0, 1'b1);
         wait_drain($sformatf("vec%0d_drain", k));
      end

      $display("[TB] back-to-back frames");
      @(posedge clk);
      #1;
      bus.p_data     = 8'h55;
      bus.par_en     = 1'b0;
      bus.par_typ    = 1'b0;
      bus.data_valid = 1'b1;
      @(posedge clk);
      #1;
      push_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      bus.p_data = 8'h0F;
      @(posedge clk);
      #1;
      bus.data_valid = 1'b0;
      push_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_drain("b2b_drain");

      $display("[TB] request during DATA is ignored");
      applyStimulus(8'hA5, 1'b1, 1'b0);
      push_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      bus.p_data     = 8'h33;
      bus.par_en     = 1'b0;
      bus.par_typ    = 1'b1;
      bus.data_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.data_valid = 1'b0;
      wait_drain("ignore_drain");

      $display("[TB] asynchronous reset mid-frame");
      applyStimulus(8'hA5, 1'b0, 1'b0);
      push_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("pre_reset_bit3", {bus.tx_out, bus.busy, bus.frame_done}, '{1'b0, 1'b1, 1'b0});
      #1;
      rst = 1'b1;
      exp_q.delete();
      #1;
      checkOutput("async_reset", {bus.tx_out, bus.busy, bus.frame_done}, '{1'b1, 1'b0, 1'b0});
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);

      applyStimulus(8'h3C, 1'b1, 1'b1);
      push_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
      wait_drain("post_reset_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmit path.
- Accepts a parallel byte with a valid strobe and latches the data plus the parity configuration.
- Drives the serial line through start, data, optional parity and stop bits.
- Contains the serializer bit counter, the parity computation and the output bit mux select.
- Sits between the host-side byte interface and the TX pad; one clk cycle equals one bit period (clk is the baud clock).

Parameters:
DATA_WIDTH, 8, number of data bits per frame (≥1), sent LSB first.

Ports:
clk  input  1  bit-rate clock; all state changes on its rising edge
rst  input  1  reset, asynchronous, active-high
p_data  input  DATA_WIDTH  parallel byte to transmit
data_valid  input  1  p_data valid this cycle; request to send
par_en  input  1  1 = insert parity bit after data bits
par_typ  input  1  0 = even parity, 1 = odd parity
tx_out  output  1  serial line, idle high
busy  output  1  frame in progress; new requests ignored except in STOP
frame_done  output  1  single-cycle pulse in the cycle after the stop bit completes

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - tx_out=1, busy=0, frame_done=0.
  - Bit counter=0; data and config registers cleared.
  - Reset mid-frame aborts the frame immediately; tx_out returns to 1 without waiting for a clock. No partial frame resumes after release.
- All outputs are registered. tx_out is driven from state plus a mux select (START→0, DATA→shift_reg[0], PARITY→par_bit, STOP/IDLE→1).
- States: IDLE, START, DATA, PARITY, STOP.
- Accept condition: data_valid=1 at a rising edge while the state is IDLE or STOP.
  - On accept, latch p_data, par_en and par_typ.
  - Compute par_bit = ^p_data XOR par_typ (even: XOR of bits; odd: inverted XOR).
  - Next state is START.
  - Later changes to p_data, par_en or par_typ have no effect on the frame in flight.
- IDLE: tx_out=1, busy=0. On accept → START. tx_out=0 and busy=1 are visible the cycle after the accepting edge, so latency is 1 clk.
- START: one cycle, tx_out=0. → DATA, with bit counter=0.
- DATA: DATA_WIDTH cycles, tx_out = current LSB of the shift register.
  - Shift right each cycle; counter increments.
  - When counter = DATA_WIDTH-1: → PARITY if the latched par_en=1, else → STOP.
- PARITY: one cycle, tx_out=par_bit. → STOP.
- STOP: one cycle, tx_out=1, busy=1.
  - At the end of STOP, if accept: → START, giving back-to-back frames with no idle bit.
  - Otherwise → IDLE.
- frame_done pulses high for exactly one cycle on the cycle after STOP, whether the next state is IDLE or START.
- data_valid during START, DATA or PARITY is ignored, not queued. The requester must hold or re-issue it.
- Frame length:
  - 1 + DATA_WIDTH + 1 cycles without parity (10 at default).
  - 1 + DATA_WIDTH + 1 + 1 cycles with parity (11 at default).
- Counter width: clog2(DATA_WIDTH)+1 bits; it never wraps within a frame. Counter resets to 0 on entry to START.
- No illegal state is reachable. An encoded default branch returns to IDLE with tx_out=1.

Test Plan:
- Reset, then p_data=0xA5, par_en=1, par_typ=0 for one cycle → tx_out sequence 0,1,0,1,0,0,1,0,1,0,1 (11 cycles). busy high for those 11 cycles; frame_done pulses on cycle 12; line then idle at 1.
- p_data=0x01, par_en=1, par_typ=1 → parity bit 0. Same byte with par_typ=0 → parity bit 1.
- p_data=0xFF, par_en=0 → 10-cycle frame 0,1,1,1,1,1,1,1,1,1 with no parity slot. busy is 1 for exactly 10 cycles.
- Back-to-back: data_valid held high with 0x55 then 0x0F presented at the STOP cycle → second start bit directly follows the first stop bit; no idle cycle; two frame_done pulses.
- Pulse data_valid with 0x33 in the middle of the DATA state of a 0xA5 frame → ignored; 0xA5 frame is bit-exact; return to IDLE afterwards.
- Assert rst asynchronously in the 4th data bit → tx_out=1, busy=0 before the next clk edge. After release, line stays idle until a new data_valid.
